// File: rtl/llr_frame_buffer_pkg.sv
// LLR frame buffer shared package.
// Default geometry, FSM encoding and saturation limit helper.
package llr_frame_buffer_pkg;

  localparam int LLR_DATA_W = 8;
  localparam int LLR_IN_W   = 10;
  localparam int LLR_R      = 5;
  localparam int LLR_D      = 8;

  localparam logic [0:0] ST_FILL   = 1'b0;
  localparam logic [0:0] ST_RESYNC = 1'b1;

  function automatic int llr_sat_lim(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/llr_frame_buffer_sat.sv
// Symmetric LLR saturation, IN_W -> DATA_W.
// Clamps to +/-(2^(DATA_W-1)-1) so the most negative code never appears.
module llr_sat
  import llr_frame_buffer_pkg::*;
#(
  parameter int IN_W   = LLR_IN_W,
  parameter int DATA_W = LLR_DATA_W
) (
  input  logic signed [IN_W-1:0]   in_llr,
  output logic signed [DATA_W-1:0] out_llr
);

  localparam int LIM = llr_sat_lim(DATA_W);
  localparam logic signed [IN_W-1:0] MAXV = IN_W'(LIM);
  localparam logic signed [IN_W-1:0] MINV = IN_W'(-LIM);

  // clamp to the symmetric range
  always_comb begin
    out_llr = in_llr[DATA_W-1:0];
    if (in_llr > MAXV)
      out_llr = MAXV[DATA_W-1:0];
    else if (in_llr < MINV)
      out_llr = MINV[DATA_W-1:0];
  end

endmodule

// File: rtl/llr_frame_buffer.sv
// Ping/pong LLR frame buffer between channel and decoder.
// Frames are committed whole; short/long frames are dropped.
module llr_frame_buffer
  import llr_frame_buffer_pkg::*;
#(
  parameter int DATA_W = LLR_DATA_W,
  parameter int IN_W   = LLR_IN_W,
  parameter int R      = LLR_R,
  parameter int D      = LLR_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W*R*D-1:0] m_llr,
  output logic                  frame_err
);

  localparam int N  = R * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [DATA_W-1:0] mem [2][N];
  logic [1:0]        full;
  logic              wptr;
  logic              rptr;
  logic [CW-1:0]     wcnt;
  logic [0:0]        state;
  logic              rdy_en;
  logic [DATA_W-1:0] sat_llr;

  logic fill;
  logic acc;
  logic at_end;
  logic commit;
  logic bad;
  logic rel;
  logic [1:0] set_m;
  logic [1:0] clr_m;

  llr_sat #(
    .IN_W  (IN_W),
    .DATA_W(DATA_W)
  ) u_sat (
    .in_llr (s_data),
    .out_llr(sat_llr)
  );

  assign fill    = (state == ST_FILL);
  assign s_ready = rdy_en & (~fill | ~full[wptr]);
  assign acc     = s_valid & s_ready;
  assign at_end  = (wcnt == CW'(N - 1));
  assign commit  = acc & fill & at_end & s_last;
  assign bad     = acc & fill & (s_last ^ at_end);
  assign m_valid = full[rptr];
  assign rel     = m_valid & m_ready;
  assign set_m   = commit ? (2'b01 << wptr) : 2'b00;
  assign clr_m   = rel ? (2'b01 << rptr) : 2'b00;

  // bank flags, pointers, write counter and framing FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 2'b00;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      wcnt      <= '0;
      state     <= ST_FILL;
      rdy_en    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      frame_err <= bad;
      full      <= (full | set_m) & ~clr_m;
      if (commit)
        wptr <= ~wptr;
      if (rel)
        rptr <= ~rptr;
      if (acc & fill)
        wcnt <= (at_end | s_last) ? '0 : wcnt + 1'b1;
      if (acc & fill & at_end & ~s_last)
        state <= ST_RESYNC;
      else if (acc & ~fill & s_last)
        state <= ST_FILL;
    end
  end

  // sample storage, no reset needed
  always_ff @(posedge clk) begin
    if (acc & fill)
      mem[wptr][wcnt] <= sat_llr;
  end

  // present the read bank
  always_comb begin
    m_llr = '0;
    for (int k = 0; k < N; k++)
      m_llr[k*DATA_W +: DATA_W] = mem[rptr][k];
  end

endmodule

// File: tb/tb_llr_frame_buffer.sv
// Directed bench for llr_frame_buffer.
// Hand-computed frames compared against m_llr.
module tb_llr_frame_buffer;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int N  = 40;
  localparam int FW = DW * N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [IW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [FW-1:0] m_llr;
  logic          frame_err;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int fv [64];
  logic [FW-1:0] fa, fb, fc;
  int e0;

  llr_frame_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_llr    (m_llr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_err) err_cnt++;

  task automatic chk(input string tag,
                     input logic [FW-1:0] act,
                     input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic logic [FW-1:0] mk_frame();
    logic [FW-1:0] f;
    int s;
    f = '0;
    for (int k = 0; k < N; k++) begin
      s = sat(fv[k]);
      f[k*DW +: DW] = s[DW-1:0];
    end
    return f;
  endfunction

  // called at a negedge; returns at the negedge after the transfer
  task automatic push(input int v, input bit last);
    int n;
    s_valid = 1'b1;
    s_data  = v[IW-1:0];
    s_last  = last;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("ready_timeout", 1'b0, 1'b1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_n(input int n, input int last_idx);
    for (int i = 0; i < n; i++)
      push(fv[i], i == last_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_pre_edge", s_ready, 1'b0);
    @(negedge clk);
    chk("ready_post_edge", s_ready, 1'b1);

    // basic frame
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) fv[k] = k - 20;
    fa = mk_frame();
    chk("basic_idle", m_valid, 1'b0);
    send_n(N, N - 1);
    chk("basic_valid", m_valid, 1'b1);
    chk("basic_data", m_llr, fa);
    chk("basic_err", frame_err, 1'b0);
    @(negedge clk);
    chk("basic_drop", m_valid, 1'b0);

    // saturation
    for (int k = 0; k < N; k++) fv[k] = k;
    fv[0] = 300; fv[1] = -300; fv[2] = 127;
    fv[3] = -128; fv[4] = 0;
    send_n(N, N - 1);
    chk("sat_valid", m_valid, 1'b1);
    chk("sat_p300", m_llr[0*DW +: DW], 8'sd127);
    chk("sat_m300", m_llr[1*DW +: DW], 8'h81);
    chk("sat_p127", m_llr[2*DW +: DW], 8'sd127);
    chk("sat_m128", m_llr[3*DW +: DW], 8'h81);
    chk("sat_zero", m_llr[4*DW +: DW], 8'h00);
    chk("sat_frame", m_llr, mk_frame());
    @(negedge clk);

    // backpressure, three frames
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) fv[k] = k;
    fa = mk_frame();
    send_n(N, N - 1);
    for (int k = 0; k < N; k++) fv[k] = 100 - 5 * k;
    fb = mk_frame();
    send_n(N, N - 1);
    chk("bp_ready_low", s_ready, 1'b0);
    chk("bp_a_valid", m_valid, 1'b1);
    chk("bp_a_data", m_llr, fa);
    repeat (5) @(negedge clk);
    chk("bp_ready_hold", s_ready, 1'b0);
    chk("bp_a_stable", m_llr, fa);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("bp_b_valid", m_valid, 1'b1);
    chk("bp_b_data", m_llr, fb);
    chk("bp_ready_back", s_ready, 1'b1);
    for (int k = 0; k < N; k++) fv[k] = -k - 50;
    fc = mk_frame();
    send_n(N, N - 1);
    chk("bp_b_stable", m_llr, fb);
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_c_valid", m_valid, 1'b1);
    chk("bp_c_data", m_llr, fc);
    @(negedge clk);
    chk("bp_empty", m_valid, 1'b0);

    // short frame
    e0 = err_cnt;
    for (int k = 0; k < N; k++) fv[k] = 7;
    send_n(10, 9);
    chk("short_err", frame_err, 1'b1);
    chk("short_nov", m_valid, 1'b0);
    @(negedge clk);
    chk("short_pulse", frame_err, 1'b0);
    chk("short_cnt", err_cnt - e0, 1);

    // long frame then resync
    e0 = err_cnt;
    for (int k = 0; k < 45; k++) fv[k] = 3;
    send_n(45, 44);
    @(negedge clk);
    chk("long_nov", m_valid, 1'b0);
    chk("long_cnt", err_cnt - e0, 1);
    for (int k = 0; k < N; k++) fv[k] = 2 * k - 39;
    fa = mk_frame();
    send_n(N, N - 1);
    chk("resync_valid", m_valid, 1'b1);
    chk("resync_data", m_llr, fa);
    @(negedge clk);
    chk("resync_cnt", err_cnt - e0, 1);

    // commit and release in the same cycle
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) fv[k] = 11 - k;
    fa = mk_frame();
    send_n(N, N - 1);
    for (int k = 0; k < N; k++) fv[k] = k * 3 - 60;
    fb = mk_frame();
    for (int i = 0; i < N - 1; i++) push(fv[i], 1'b0);
    chk("sim_a_data", m_llr, fa);
    m_ready = 1'b1;
    push(fv[N-1], 1'b1);
    chk("sim_valid", m_valid, 1'b1);
    chk("sim_b_data", m_llr, fb);
    @(negedge clk);
    chk("sim_empty", m_valid, 1'b0);

    // reset mid-operation
    e0 = err_cnt;
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) fv[k] = 20;
    send_n(N, N - 1);
    send_n(20, -1);
    chk("mid_pending", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_ready", s_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) fv[k] = 39 - 2 * k;
    fa = mk_frame();
    send_n(N, N - 1);
    chk("mid_valid", m_valid, 1'b1);
    chk("mid_data", m_llr, fa);
    @(negedge clk);
    chk("mid_no_err", err_cnt - e0, 0);
    chk("mid_empty", m_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
